// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue stage and its register file:
//   ALU_W       - datapath width (32)
//   alu_op_e    - ALU operation encodings (ADD/SUB/MUL/LSR/AND)
//   ex_state_e  - EX-stage occupancy states
//   op_is_legal - true for the five implemented opcodes
// Optional feature macro: ALU_MUL_STALL_EN adds the EX_MUL1 state used when a
// multiply is given two EX cycles.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_LSR = 3'b011,
    OP_AND = 3'b100
  } alu_op_e;

`ifdef ALU_MUL_STALL_EN
  typedef enum logic [1:0] {
    EX_IDLE = 2'd0,
    EX_BUSY = 2'd1,
    EX_MUL1 = 2'd2
  } ex_state_e;
`else
  typedef enum logic [1:0] {
    EX_IDLE = 2'd0,
    EX_BUSY = 2'd1
  } ex_state_e;
`endif

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= 3'b100);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
// NREGS x ALU_W register file: two asynchronous read ports, one synchronous
// write port. All entries clear on reset. r0 is hard-wired: writes to it are
// dropped, so it always reads as zero.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   ra_addr / ra_data   - read port A
//   rb_addr / rb_data   - read port B
//   we, waddr, wdata    - write port, committed at the rising edge
// -----------------------------------------------------------------------------
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [$clog2(NREGS)-1:0]   ra_addr,
  output logic [ALU_W-1:0]           ra_data,
  input  logic [$clog2(NREGS)-1:0]   rb_addr,
  output logic [ALU_W-1:0]           rb_data,
  input  logic                       we,
  input  logic [$clog2(NREGS)-1:0]   waddr,
  input  logic [ALU_W-1:0]           wdata
);

  logic [ALU_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Execute-issue stage in front of the ALU. Accepts decoded instructions over a
// valid/ready handshake, resolves operands (r0 / forwarded ALU result /
// register file), registers Opa/Opb/ALUSignal for the ALU and writes the ALU
// result back into the register file at the end of the instruction's final
// EX cycle.
// Optional feature macro: ALU_MUL_STALL_EN - MUL occupies two EX cycles with
// operands held; writeback only in the second cycle and in_ready low in the
// first.
// Ports:
//   clk, rst_n                       - clock, asynchronous active-low reset
//   in_valid / in_ready              - instruction handshake
//   in_op, in_rd, in_rs1, in_rs2     - opcode and register indices
//   in_imm, in_use_imm               - immediate and B-operand select
//   Opa, Opb, ALUSignal, alu_valid   - registered ALU drive
//   ALUResult                        - combinational ALU result
//   wb_en, wb_rd, wb_data            - register file write this cycle
// -----------------------------------------------------------------------------
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_op,
  input  logic [$clog2(NREGS)-1:0]   in_rd,
  input  logic [$clog2(NREGS)-1:0]   in_rs1,
  input  logic [$clog2(NREGS)-1:0]   in_rs2,
  input  logic [ALU_W-1:0]           in_imm,
  input  logic                       in_use_imm,
  output logic [ALU_W-1:0]           Opa,
  output logic [ALU_W-1:0]           Opb,
  output logic [2:0]                 ALUSignal,
  output logic                       alu_valid,
  input  logic [ALU_W-1:0]           ALUResult,
  output logic                       wb_en,
  output logic [$clog2(NREGS)-1:0]   wb_rd,
  output logic [ALU_W-1:0]           wb_data
);

  localparam int AW = $clog2(NREGS);

  ex_state_e       state;
  ex_state_e       state_nxt;
  logic [AW-1:0]   rd_p1;
  logic            legal_p1;
  logic            accept;
  logic            in_legal;
  logic [ALU_W-1:0] rf_a;
  logic [ALU_W-1:0] rf_b;
  logic [ALU_W-1:0] src_a;
  logic [ALU_W-1:0] src_b;
  logic            final_cycle;

  // Operand source priority: r0, then the result being written back this
  // cycle, then the register file. The forward covers distance-1 hazards and
  // also hides the same-cycle write/read race on the register file.
  function automatic logic [ALU_W-1:0] resolve_src(
    input logic [AW-1:0]    r,
    input logic [ALU_W-1:0] rf_val,
    input logic             fwd_en,
    input logic [AW-1:0]    fwd_rd,
    input logic [ALU_W-1:0] fwd_val
  );
    if (r == '0)                    return '0;
    else if (fwd_en && fwd_rd == r) return fwd_val;
    else                            return rf_val;
  endfunction

  alu_regfile #(.NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (in_rs1),
    .ra_data (rf_a),
    .rb_addr (in_rs2),
    .rb_data (rf_b),
    .we      (wb_en),
    .waddr   (wb_rd),
    .wdata   (ALUResult)
  );

`ifdef ALU_MUL_STALL_EN
  assign in_ready = rst_n & (state != EX_MUL1);
`else
  assign in_ready = rst_n;
`endif

  assign accept   = in_valid & in_ready;
  assign in_legal = op_is_legal(in_op);

  assign src_a = resolve_src(in_rs1, rf_a, wb_en, wb_rd, ALUResult);
  assign src_b = in_use_imm ? in_imm
                            : resolve_src(in_rs2, rf_b, wb_en, wb_rd, ALUResult);

  // ---- stage p1: issued instruction in EX ----

  // Only the last EX cycle of an instruction commits; with the stall enabled a
  // MUL spends its first cycle in EX_MUL1 and must not write back yet.
  assign final_cycle = (state == EX_BUSY);
  assign wb_en       = alu_valid & (rd_p1 != '0) & legal_p1 & final_cycle;
  assign wb_rd       = rd_p1;
  assign wb_data     = ALUResult;

  always_comb begin
    state_nxt = state;
    case (state)
`ifdef ALU_MUL_STALL_EN
      EX_MUL1: state_nxt = EX_BUSY;
`endif
      default: begin
        if (accept) begin
`ifdef ALU_MUL_STALL_EN
          state_nxt = (in_op == OP_MUL) ? EX_MUL1 : EX_BUSY;
`else
          state_nxt = EX_BUSY;
`endif
        end else begin
          state_nxt = EX_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EX_IDLE;
      alu_valid <= 1'b0;
      Opa       <= '0;
      Opb       <= '0;
      ALUSignal <= '0;
      rd_p1     <= '0;
      legal_p1  <= 1'b0;
    end else begin
      state <= state_nxt;
`ifdef ALU_MUL_STALL_EN
      // A stalled MUL stays live into its second cycle with operands held.
      alu_valid <= accept | (state == EX_MUL1);
`else
      alu_valid <= accept;
`endif
      if (accept) begin
        Opa       <= src_a;
        Opb       <= src_b;
        // Illegal codes still drive a harmless AND; their writeback is masked.
        ALUSignal <= in_legal ? in_op : OP_AND;
        rd_p1     <= in_rd;
        legal_p1  <= in_legal;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
// Directed bench for alu_issue_stage. A small behavioural ALU closes the loop
// from Opa/Opb/ALUSignal to ALUResult. Expected values are hand-computed.
// Handles builds with and without ALU_MUL_STALL_EN.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [3:0]  in_rd;
  logic [3:0]  in_rs1;
  logic [3:0]  in_rs2;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [31:0] Opa;
  logic [31:0] Opb;
  logic [2:0]  ALUSignal;
  logic        alu_valid;
  logic [31:0] ALUResult;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;

  int errors = 0;
  int checks = 0;

  alu_issue_stage #(.NREGS(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .in_use_imm (in_use_imm),
    .Opa        (Opa),
    .Opb        (Opb),
    .ALUSignal  (ALUSignal),
    .alu_valid  (alu_valid),
    .ALUResult  (ALUResult),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU
  logic [63:0] prod;
  always_comb begin
    prod = Opa * Opb;
    case (ALUSignal)
      3'b000:  ALUResult = Opa + Opb;
      3'b001:  ALUResult = Opa - Opb;
      3'b010:  ALUResult = prod[31:0];
      3'b011:  ALUResult = Opa >> Opb[4:0];
      default: ALUResult = Opa & Opb;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [31:0] imm, input logic ui);
    in_valid   = v;
    in_op      = op;
    in_rd      = rd;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_imm     = imm;
    in_use_imm = ui;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 32'd0, 1'b0);
    #3;
    chk("rst_opa", Opa, 32'd0);
    chk("rst_opb", Opb, 32'd0);
    chk("rst_sig", {29'd0, ALUSignal}, 32'd0);
    chk("rst_valid", {31'd0, alu_valid}, 32'd0);
    chk("rst_wben", {31'd0, wb_en}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // ADD r1 <- r0 + 5, then dependent ADD r2 <- r1 + 7 back-to-back
    drive(1'b1, 3'b000, 4'd1, 4'd0, 4'd0, 32'd5, 1'b1);
    step();
    chk("add1_opa", Opa, 32'd0);
    chk("add1_opb", Opb, 32'd5);
    chk("add1_valid", {31'd0, alu_valid}, 32'd1);
    chk("add1_wben", {31'd0, wb_en}, 32'd1);
    chk("add1_wbrd", {28'd0, wb_rd}, 32'd1);
    chk("add1_wbdata", wb_data, 32'd5);
    drive(1'b1, 3'b000, 4'd2, 4'd1, 4'd0, 32'd7, 1'b1);
    step();
    chk("add2_opa_fwd", Opa, 32'd5);
    chk("add2_opb", Opb, 32'd7);
    chk("add2_wbdata", wb_data, 32'd12);
    chk("add2_wbrd", {28'd0, wb_rd}, 32'd2);

    // Two idle cycles, then SUB r3 <- r2 - r1 from the register file
    drive(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 32'd0, 1'b0);
    step();
    chk("idle_valid", {31'd0, alu_valid}, 32'd0);
    chk("idle_wben", {31'd0, wb_en}, 32'd0);
    chk("idle_hold_opa", Opa, 32'd5);
    step();
    drive(1'b1, 3'b001, 4'd3, 4'd2, 4'd1, 32'd0, 1'b0);
    step();
    chk("sub_opa", Opa, 32'd12);
    chk("sub_opb_rf", Opb, 32'd5);
    chk("sub_sig", {29'd0, ALUSignal}, 32'd1);
    chk("sub_wbdata", wb_data, 32'd7);

    // LSR r4 <- r3 >> 1 (r3 forwarded), then AND r5 <- r4 & 0xF
    drive(1'b1, 3'b011, 4'd4, 4'd3, 4'd0, 32'd1, 1'b1);
    step();
    chk("lsr_opa_fwd", Opa, 32'd7);
    chk("lsr_wbdata", wb_data, 32'd3);
    drive(1'b1, 3'b100, 4'd5, 4'd4, 4'd0, 32'hF, 1'b1);
    step();
    chk("and_opa_fwd", Opa, 32'd3);
    chk("and_sig", {29'd0, ALUSignal}, 32'd4);
    chk("and_wbdata", wb_data, 32'd3);
    chk("and_wbrd", {28'd0, wb_rd}, 32'd5);

    // MUL r6 <- r3 * r3 with a dependent ADD r8 <- r6 + 0 held valid behind it
    drive(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 32'd0, 1'b0);
    step();
    drive(1'b1, 3'b010, 4'd6, 4'd3, 4'd3, 32'd0, 1'b0);
    step();
    drive(1'b1, 3'b000, 4'd8, 4'd6, 4'd0, 32'd0, 1'b1);
    chk("mul_opa", Opa, 32'd7);
    chk("mul_opb", Opb, 32'd7);
    chk("mul_sig", {29'd0, ALUSignal}, 32'd2);
`ifdef ALU_MUL_STALL_EN
    chk("mul1_ready", {31'd0, in_ready}, 32'd0);
    chk("mul1_wben", {31'd0, wb_en}, 32'd0);
    step();
    chk("mul2_hold_opa", Opa, 32'd7);
    chk("mul2_valid", {31'd0, alu_valid}, 32'd1);
    chk("mul2_ready", {31'd0, in_ready}, 32'd1);
`else
    chk("mul_ready", {31'd0, in_ready}, 32'd1);
`endif
    chk("mul_wben", {31'd0, wb_en}, 32'd1);
    chk("mul_wbdata", wb_data, 32'd49);
    chk("mul_wbrd", {28'd0, wb_rd}, 32'd6);
    step();
    chk("after_mul_opa_fwd", Opa, 32'd49);

    // Writes to r0 and illegal opcodes are suppressed
    drive(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 32'd9, 1'b1);
    step();
    chk("r0_wben", {31'd0, wb_en}, 32'd0);
    drive(1'b1, 3'b110, 4'd7, 4'd3, 4'd0, 32'hFF, 1'b1);
    step();
    chk("illegal_wben", {31'd0, wb_en}, 32'd0);
    chk("illegal_sig_and", {29'd0, ALUSignal}, 32'd4);
    drive(1'b1, 3'b000, 4'd9, 4'd0, 4'd7, 32'd0, 1'b0);
    step();
    chk("r0_reads_zero", Opa, 32'd0);
    chk("r7_unchanged", Opb, 32'd0);

    // Reset in the middle of a MUL: nothing is written back
    drive(1'b1, 3'b010, 4'd11, 4'd3, 4'd3, 32'd0, 1'b0);
    step();
    drive(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 32'd0, 1'b0);
    chk("mid_mul_valid", {31'd0, alu_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, alu_valid}, 32'd0);
    chk("mid_rst_opa", Opa, 32'd0);
    chk("mid_rst_opb", Opb, 32'd0);
    chk("mid_rst_wben", {31'd0, wb_en}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 3'b000, 4'd12, 4'd11, 4'd3, 32'd0, 1'b0);
    step();
    chk("r11_not_written", Opa, 32'd0);
    chk("r3_cleared", Opb, 32'd0);
    drive(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 32'd0, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
